// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit with a parametrised set-associative I-cache (1 or 2 ways).
// Issues one 32-bit word per cycle on hit, refills whole lines from memory on miss.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no refill outstanding; a miss launches a line request
// S_REFILL  | request outstanding for the current pc; the line is installed on return
// S_DISCARD | request outstanding but redirected away; the line is dropped on return
module inst_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                LINE_BYTES = 16,
    parameter int                SETS       = 16,
    parameter int                WAYS       = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    stall_in,
    output logic                    mem_valid,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_ready,
    input  logic [LINE_BYTES*8-1:0] mem_line,
    output logic                    issue_valid,
    output logic [ADDR_W-1:0]       issue_pc,
    output logic [ADDR_W-1:0]       issue_next_pc,
    output logic [31:0]             issue_inst,
    input  logic                    redirect_valid,
    input  logic [ADDR_W-1:0]       redirect_pc,
    input  logic                    inval
);
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_DISCARD} state_t;

    logic [LINE_W-1:0] data_q  [WAYS][SETS];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [SETS-1:0]   valid_q [WAYS];
    logic [SETS-1:0]   lru_q;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_valid_q, mem_valid_d;
    logic              fill_en;

    logic [IDX_W-1:0]  pc_idx, fill_idx;
    logic [TAG_W-1:0]  pc_tag, fill_tag;
    logic              hit, hit_way, victim, accept;
    logic [LINE_W-1:0] hit_line;
    logic [OFF_W-1:0]  byte_off;
    logic [OFF_W+2:0]  bit_off;

    assign pc_idx   = pc_q[OFF_W +: IDX_W];
    assign pc_tag   = pc_q[ADDR_W-1 -: TAG_W];
    assign fill_idx = mem_addr_q[OFF_W +: IDX_W];
    assign fill_tag = mem_addr_q[ADDR_W-1 -: TAG_W];

    // Lowest-numbered matching way wins; duplicates cannot arise since only missing lines are filled.
    always_comb begin
        hit     = 1'b0;
        hit_way = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][pc_idx] && (tag_q[w][pc_idx] == pc_tag)) begin
                hit     = 1'b1;
                hit_way = 1'(w);
            end
        end
    end

    always_comb begin
        victim = 1'b0;
        if (WAYS == 2) begin
            if (!valid_q[0][fill_idx])
                victim = 1'b0;
            else if (!valid_q[WAYS-1][fill_idx])
                victim = 1'b1;
            else
                victim = lru_q[fill_idx];
        end
    end

    assign hit_line      = data_q[hit_way][pc_idx];
    assign byte_off      = pc_q[OFF_W-1:0] & ~OFF_W'(3);
    assign bit_off       = {byte_off, 3'b000};
    assign issue_valid   = hit & rdy;
    assign issue_inst    = issue_valid ? hit_line[bit_off +: 32] : 32'h0;
    assign issue_pc      = pc_q;
    assign issue_next_pc = pc_q + ADDR_W'(4);
    assign mem_valid     = mem_valid_q;
    assign mem_addr      = mem_addr_q;
    assign accept        = issue_valid & ~stall_in & ~redirect_valid;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid)
            pc_d = redirect_pc;
        else if (issue_valid && !stall_in)
            pc_d = pc_q + ADDR_W'(4);
    end

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        fill_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!hit && !redirect_valid) begin
                    mem_valid_d = 1'b1;
                    mem_addr_d  = {pc_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    state_d     = S_REFILL;
                end
            end
            S_REFILL: begin
                if (mem_ready) begin
                    fill_en     = 1'b1;
                    mem_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (redirect_valid) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            lru_q       <= '0;
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
        end else if (rdy) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            if (inval) begin
                lru_q <= '0;
                for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            end else begin
                if (accept)
                    lru_q[pc_idx] <= ~hit_way;
                if (fill_en) begin
                    valid_q[victim][fill_idx] <= 1'b1;
                    lru_q[fill_idx]           <= ~victim;
                end
            end
        end
    end

    // Payload arrays need no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (rst && rdy && fill_en && !inval) begin
            data_q[victim][fill_idx] <= mem_line;
            tag_q[victim][fill_idx]  <= fill_tag;
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed, table-driven bench for inst_fetch_unit at default geometry
// (32-bit PC, 16-byte lines, 16 sets, 2 ways, reset PC 0).
module tb_inst_fetch_unit;
    logic         clk = 1'b0;
    logic         rst, rdy, stall_in, mem_ready, redirect_valid, inval;
    logic [31:0]  redirect_pc;
    logic [127:0] mem_line;
    logic         mem_valid, issue_valid;
    logic [31:0]  mem_addr, issue_pc, issue_next_pc, issue_inst;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk(clk), .rst(rst), .rdy(rdy), .stall_in(stall_in),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_line(mem_line),
        .issue_valid(issue_valid), .issue_pc(issue_pc), .issue_next_pc(issue_next_pc),
        .issue_inst(issue_inst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inval(inval)
    );

    typedef struct {
        logic        rdy, stall, mr, rv;
        logic [31:0] rpc;
        logic        inv;
        logic [31:0] lb;
        logic        e_mv;
        logic [31:0] e_ma;
        logic        e_iv;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [127:0] line_for(input logic [31:0] base);
        logic [127:0] l;
        logic [15:0]  lo;
        if (base == 32'h0) begin
            l = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
        end else begin
            l = '0;
            for (int j = 0; j < 4; j++) begin
                lo = base[15:0] + 16'(4 * j);
                l[j*32 +: 32] = {16'hC0DE, lo};
            end
        end
        return l;
    endfunction

    function automatic logic [31:0] word_for(input logic [31:0] pc);
        logic [127:0] l;
        l = line_for({pc[31:4], 4'b0000});
        return l[pc[3:2]*32 +: 32];
    endfunction

    function automatic void add(input logic r, st, mr, rv, input logic [31:0] rpc,
                                input logic inv, input logic [31:0] lb,
                                input logic emv, input logic [31:0] ema,
                                input logic eiv, input logic [31:0] epc);
        vec_t t;
        t.rdy = r; t.stall = st; t.mr = mr; t.rv = rv; t.rpc = rpc; t.inv = inv; t.lb = lb;
        t.e_mv = emv; t.e_ma = ema; t.e_iv = eiv; t.e_pc = epc;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic defaults();
        rdy = 1'b1; stall_in = 1'b0; mem_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; inval = 1'b0; mem_line = line_for(32'h0);
    endtask

    initial begin
        rst = 1'b0;
        defaults();

        //   rdy st mr rv rpc           inv lb             mv ma             iv pc
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0);        // 0 reset state, cold miss
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 32'h0);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 32'h0);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 32'h0);
        add(1, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 32'h0);        // 4 line returns
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h0);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h4);
        add(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h8);        // 7 stall x4
        add(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h8);
        add(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h8);
        add(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h8);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h8);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'hC);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h10);       // 13 miss 0x10
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       0, 32'h10);
        add(1, 0, 0, 1, 32'h40,       0, 32'h0,        1, 32'h10,       0, 32'h10);       // 15 redirect mid-refill
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       0, 32'h40);
        add(1, 0, 1, 0, 32'h0,        0, 32'h10,       1, 32'h10,       0, 32'h40);       // 17 dropped line
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h10,       0, 32'h40);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h40,       0, 32'h40);
        add(1, 0, 1, 0, 32'h0,        0, 32'h40,       1, 32'h40,       0, 32'h40);
        add(1, 0, 0, 1, 32'h10,       0, 32'h0,        0, 32'h40,       1, 32'h40);       // 21 hit not consumed
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h40,       0, 32'h10);       // 22 0x10 misses again
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       0, 32'h10);
        add(1, 0, 1, 0, 32'h0,        0, 32'h10,       1, 32'h10,       0, 32'h10);
        add(1, 0, 0, 1, 32'h100,      0, 32'h0,        0, 32'h10,       1, 32'h10);       // 25 conflict set 0
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h10,       0, 32'h100);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h100,      0, 32'h100);
        add(1, 0, 1, 0, 32'h0,        0, 32'h100,      1, 32'h100,      0, 32'h100);
        add(1, 0, 0, 1, 32'h0,        0, 32'h0,        0, 32'h100,      1, 32'h100);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h100,      1, 32'h0);        // 30 accepted hit way 0
        add(1, 0, 0, 1, 32'h200,      0, 32'h0,        0, 32'h100,      1, 32'h4);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h100,      0, 32'h200);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h200,      0, 32'h200);
        add(1, 0, 1, 0, 32'h0,        0, 32'h200,      1, 32'h200,      0, 32'h200);
        add(1, 0, 0, 1, 32'h0,        0, 32'h0,        0, 32'h200,      1, 32'h200);
        add(1, 0, 0, 1, 32'h100,      0, 32'h0,        0, 32'h200,      1, 32'h0);        // 36 0x000 survived
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h200,      0, 32'h100);      // 37 0x100 evicted
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h100,      0, 32'h100);
        add(1, 0, 1, 0, 32'h0,        1, 32'h100,      1, 32'h100,      0, 32'h100);      // 39 inval with fill
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h100,      0, 32'h100);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h100,      0, 32'h100);
        add(0, 0, 1, 0, 32'h0,        0, 32'h100,      1, 32'h100,      0, 32'h100);      // 42 ready ignored
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h100,      0, 32'h100);
        add(1, 0, 1, 0, 32'h0,        0, 32'h100,      1, 32'h100,      0, 32'h100);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h100,      1, 32'h100);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h100,      0, 32'h104);      // 46 rdy low masks issue
        add(1, 0, 0, 1, 32'hFFFFFFFC, 0, 32'h0,        0, 32'h100,      1, 32'h104);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h100,      0, 32'hFFFFFFFC);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFFFFF0, 0, 32'hFFFFFFFC);
        add(1, 0, 1, 0, 32'h0,        0, 32'hFFFFFFF0, 1, 32'hFFFFFFF0, 0, 32'hFFFFFFFC);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'hFFFFFFF0, 1, 32'hFFFFFFFC); // 51 pc wraps
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'hFFFFFFF0, 0, 32'h0);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 32'h0);        // 53 REFILL pending

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst            = 1'b1;
            rdy            = vecs[i].rdy;
            stall_in       = vecs[i].stall;
            mem_ready      = vecs[i].mr;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            inval          = vecs[i].inv;
            mem_line       = line_for(vecs[i].lb);
            #2;
            chk($sformatf("row%0d mem_valid", i), 32'(mem_valid), 32'(vecs[i].e_mv));
            chk($sformatf("row%0d mem_addr", i), mem_addr, vecs[i].e_ma);
            chk($sformatf("row%0d issue_valid", i), 32'(issue_valid), 32'(vecs[i].e_iv));
            chk($sformatf("row%0d issue_pc", i), issue_pc, vecs[i].e_pc);
            chk($sformatf("row%0d issue_next_pc", i), issue_next_pc, vecs[i].e_pc + 32'd4);
            chk($sformatf("row%0d issue_inst", i), issue_inst,
                vecs[i].e_iv ? word_for(vecs[i].e_pc) : 32'h0);
        end

        // Reset while a refill is outstanding, then a stray ready that must not install anything.
        @(negedge clk);
        defaults();
        rst = 1'b0;
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b1;
        #2;
        chk("rst mem_valid", 32'(mem_valid), 32'd0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst issue_pc", issue_pc, 32'h0);
        chk("rst issue_valid", 32'(issue_valid), 32'd0);
        @(negedge clk);
        defaults();
        #2;
        chk("post-rst request", 32'(mem_valid), 32'd1);
        chk("stray ready not installed", 32'(issue_valid), 32'd0);
        mem_ready = 1'b1;
        @(negedge clk);
        defaults();
        #2;
        chk("refill after rst valid", 32'(issue_valid), 32'd1);
        chk("refill after rst inst", issue_inst, 32'h33221100);
        chk("refill after rst mem_valid", 32'(mem_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
